// File: rtl/led_scan_controller.sv
// Double-buffered multi-panel LED scan driver with PWM slots and row blanking.
// Define GLOBAL_DIM_EN to add the per-row global_dim brightness input.
module led_scan_controller #(
  parameter int NUM_PANELS      = 4,
  parameter int CHANS_PER_PANEL = 3,
  parameter int NUM_ROWS        = 16,
  parameter int COLS            = 16,
  parameter int PWM_BITS        = 8,
  parameter int BLANK_CYCLES    = 4,
  localparam int PW  = (NUM_PANELS > 1) ? $clog2(NUM_PANELS) : 1,
  localparam int RW  = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
  localparam int CLW = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int DW  = CHANS_PER_PANEL * PWM_BITS,
  localparam int NCH = NUM_PANELS * CHANS_PER_PANEL
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [PW-1:0]     wr_panel,
  input  logic [RW-1:0]     wr_row,
  input  logic [CLW-1:0]    wr_col,
  input  logic [DW-1:0]     wr_data,
  input  logic              swap_req,
`ifdef GLOBAL_DIM_EN
  input  logic [PWM_BITS-1:0] global_dim,
`endif
  output logic              swap_ack,
  output logic              serial_clk,
  output logic              latch_enable,
  output logic              output_enable_n,
  output logic [NCH-1:0]    serial_data_out,
  output logic [NUM_ROWS-1:0] row_select_n
);

  localparam int CNTMAX = (2 * COLS > BLANK_CYCLES) ? 2 * COLS : BLANK_CYCLES;
  localparam int CW     = (CNTMAX > 1) ? $clog2(CNTMAX) : 1;
  localparam int DEPTH  = 2 * NUM_PANELS * NUM_ROWS * COLS;
  localparam int AW     = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_BLANK,
    S_SHIFT,
    S_LATCH
  } state_t;

  state_t              r_state;
  state_t              w_state_n;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       w_cnt_n;
  logic [RW-1:0]       r_row;
  logic [RW-1:0]       w_row_n;
  logic [PWM_BITS-1:0] r_pwm;
  logic [PWM_BITS-1:0] w_pwm_n;
  logic                r_bank;
  logic                w_bank_n;
  logic                r_pend;
  logic                w_pend_n;
  logic                r_run;
  logic                w_swap;

  logic                r_sclk;
  logic                r_le;
  logic                r_oe_n;
  logic [NCH-1:0]      r_sdo;
  logic [NUM_ROWS-1:0] r_rsel;
  logic                r_ack;

  logic                w_sclk;
  logic                w_le;
  logic                w_oe_n;
  logic [NCH-1:0]      w_sdo;
  logic [NUM_ROWS-1:0] w_rsel;
  logic [CLW-1:0]      w_col_n;
  logic [DW-1:0]       w_word;

  logic [DW-1:0]       r_mem [DEPTH];
  logic                w_wr_ok;
  logic [AW-1:0]       w_waddr;

`ifdef GLOBAL_DIM_EN
  logic [PWM_BITS-1:0] r_dim;
  logic [PWM_BITS-1:0] w_dim;
`endif

  function automatic logic [AW-1:0] f_addr(
    input logic           b,
    input logic [PW-1:0]  p,
    input logic [RW-1:0]  r,
    input logic [CLW-1:0] c
  );
    int a;
    a = ((int'(b) * NUM_PANELS + int'(p)) * NUM_ROWS + int'(r))
        * COLS + int'(c);
    return a[AW-1:0];
  endfunction

  assign w_wr_ok = wr_en
                 && (int'(wr_panel) < NUM_PANELS)
                 && (int'(wr_row) < NUM_ROWS)
                 && (int'(wr_col) < COLS);
  assign w_waddr = f_addr(~r_bank, wr_panel, wr_row, wr_col);

  // The frame store has no reset; writes land in the bank not on display.
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[w_waddr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_BLANK;
      r_cnt   <= '0;
      r_row   <= '0;
      r_pwm   <= '0;
      r_bank  <= 1'b0;
      r_pend  <= 1'b0;
      r_run   <= 1'b0;
      r_sclk  <= 1'b0;
      r_le    <= 1'b0;
      r_oe_n  <= 1'b1;
      r_sdo   <= '0;
      r_rsel  <= '1;
      r_ack   <= 1'b0;
`ifdef GLOBAL_DIM_EN
      r_dim   <= '0;
`endif
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_row   <= w_row_n;
      r_pwm   <= w_pwm_n;
      r_bank  <= w_bank_n;
      r_pend  <= w_pend_n;
      r_run   <= 1'b1;
      r_sclk  <= w_sclk;
      r_le    <= w_le;
      r_oe_n  <= w_oe_n;
      r_sdo   <= w_sdo;
      r_rsel  <= w_rsel;
      r_ack   <= w_swap;
`ifdef GLOBAL_DIM_EN
      r_dim   <= w_dim;
`endif
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_row_n   = r_row;
    w_pwm_n   = r_pwm;
    w_swap    = 1'b0;
    if (r_run) begin
      unique case (r_state)
        S_BLANK: begin
          if (r_cnt == CW'(BLANK_CYCLES - 1)) begin
            w_state_n = S_SHIFT;
            w_cnt_n   = '0;
            w_pwm_n   = '0;
          end else begin
            w_cnt_n = r_cnt + 1'b1;
          end
        end
        S_SHIFT: begin
          if (r_cnt == CW'(2 * COLS - 1)) begin
            w_state_n = S_LATCH;
            w_cnt_n   = '0;
          end else begin
            w_cnt_n = r_cnt + 1'b1;
          end
        end
        S_LATCH: begin
          w_pwm_n = r_pwm + 1'b1;
          if (&r_pwm) begin
            w_state_n = S_BLANK;
            if (r_row == RW'(NUM_ROWS - 1)) begin
              w_row_n = '0;
              w_swap  = r_pend | swap_req;
            end else begin
              w_row_n = r_row + 1'b1;
            end
          end else begin
            w_state_n = S_SHIFT;
          end
        end
        default: w_state_n = S_BLANK;
      endcase
    end
  end

  assign w_bank_n = r_bank ^ w_swap;
  assign w_pend_n = (r_pend | swap_req) & ~w_swap;

`ifdef GLOBAL_DIM_EN
  assign w_dim = (r_state == S_BLANK && r_cnt == '0) ? global_dim : r_dim;
`endif

  // Outputs are registered from next-state values, so the frame store
  // is read one cycle ahead of each low phase.
  assign w_col_n = CLW'(COLS - 1) - CLW'(w_cnt_n >> 1);

  always_comb begin
    w_sclk = (w_state_n == S_SHIFT) & w_cnt_n[0];
    w_le   = (w_state_n == S_LATCH);
    w_oe_n = (w_state_n == S_BLANK);
`ifdef GLOBAL_DIM_EN
    w_oe_n = w_oe_n | (w_pwm_n >= w_dim);
`endif
    w_rsel = ~(NUM_ROWS'(1) << w_row_n);
    w_sdo  = '0;
    w_word = '0;
    for (int p = 0; p < NUM_PANELS; p++) begin
      w_word = r_mem[f_addr(w_bank_n, PW'(p), w_row_n, w_col_n)];
      for (int c = 0; c < CHANS_PER_PANEL; c++) begin
        if (w_state_n == S_SHIFT)
          w_sdo[p * CHANS_PER_PANEL + c] =
            (w_word[c * PWM_BITS +: PWM_BITS] > w_pwm_n);
      end
    end
  end

  assign swap_ack        = r_ack;
  assign serial_clk      = r_sclk;
  assign latch_enable    = r_le;
  assign output_enable_n = r_oe_n;
  assign serial_data_out = r_sdo;
  assign row_select_n    = r_rsel;

endmodule
